// File: rtl/marquee_shifter.sv
// marquee_shifter: rotating-display engine that presents a moving window of a
// loaded pattern to the 7-segment scanner. It has a single clock domain, and
// the shift rate comes from an internal tick divider.
//
// Ports:
//   sys_clk_in  system clock, all logic on the rising edge
//   reset       asynchronous active-low reset
//   pause       1 = freeze the offset and the tick counter
//   mode        00 rotate left, 01 rotate right, 10 ping-pong, 11 one-shot
//   step        bits moved per tick, applied modulo WIDTH
//   load_valid  a new pattern is offered on binary_in
//   load_ready  the block can accept a pattern this cycle
//   binary_in   pattern to load
//   binary_out  rotl(data, offset)
//   window_out  top WIN_BITS of binary_out
//   offset      current rotate-left amount
//   tick_out    one-cycle pulse on each shift tick
//   done        one-shot scroll finished (level)
module marquee_shifter #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned WIN_BITS = 16,
   parameter int unsigned STEP_W   = 5,
   parameter int unsigned DIV      = 100_000_000,
   parameter int unsigned OFF_W    = $clog2(WIDTH)
) (
   input  logic                sys_clk_in,
   input  logic                reset,
   input  logic                pause,
   input  logic [1:0]          mode,
   input  logic [STEP_W-1:0]   step,
   input  logic                load_valid,
   output logic                load_ready,
   input  logic [WIDTH-1:0]    binary_in,
   output logic [WIDTH-1:0]    binary_out,
   output logic [WIN_BITS-1:0] window_out,
   output logic [OFF_W-1:0]    offset,
   output logic                tick_out,
   output logic                done
);

   localparam int unsigned      CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [OFF_W-1:0] MAXO     = OFF_W'(WIDTH - WIN_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [OFF_W:0]   WIDTH_X  = (OFF_W+1)'(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [OFF_W-1:0]   off_q, off_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               dir_q, dir_d;
   logic               done_q, done_d;

   logic               tick;
   logic               accept;
   logic [OFF_W-1:0]   s;
   logic [OFF_W-1:0]   o_clamp;
   logic [OFF_W:0]     sum_w;
   logic [OFF_W:0]     sum_c;
   logic [OFF_W-1:0]   rot_l;
   logic [OFF_W-1:0]   rot_r;

   // Tick fires on the last count of a running, unpaused divider period.
   assign tick       = (state_q == S_RUN) && !pause && (cnt_q == CNT_LAST);
   assign tick_out   = tick;
   assign load_ready = !tick;
   assign accept     = load_valid && !tick;

   // Per-tick arithmetic, all kept inside 0..WIDTH-1.
   assign s       = OFF_W'(32'(step) % WIDTH);
   assign o_clamp = (off_q > MAXO) ? MAXO : off_q;
   assign sum_w   = {1'b0, off_q} + {1'b0, s};
   assign sum_c   = {1'b0, o_clamp} + {1'b0, s};
   assign rot_l   = (sum_w >= WIDTH_X) ? OFF_W'(sum_w - WIDTH_X) : OFF_W'(sum_w);
   assign rot_r   = (off_q >= s) ? (off_q - s)
                                 : OFF_W'(WIDTH_X - {1'b0, s} + {1'b0, off_q});

   // State and datapath registers.
   always_ff @(posedge sys_clk_in or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         off_q   <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         off_q   <= off_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: a tick consumes the cycle, otherwise a load wins.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      off_d   = off_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      done_d  = done_q;

      if (tick) begin
         cnt_d = '0;
         unique case (mode)
            2'b00: off_d = rot_l;
            2'b01: off_d = rot_r;
            2'b10: begin
               if (!dir_q) begin
                  if (sum_c >= {1'b0, MAXO}) begin
                     off_d = MAXO;
                     dir_d = 1'b1;
                  end else begin
                     off_d = OFF_W'(sum_c);
                  end
               end else begin
                  if (o_clamp <= s) begin
                     off_d = '0;
                     dir_d = 1'b0;
                  end else begin
                     off_d = o_clamp - s;
                  end
               end
            end
            default: begin
               // A zero step never reaches the end, so the scroll never finishes.
               if ((sum_c >= {1'b0, MAXO}) && (s != '0)) begin
                  off_d   = MAXO;
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  off_d = OFF_W'(sum_c);
               end
            end
         endcase
      end else if (accept) begin
         data_d  = binary_in;
         off_d   = '0;
         dir_d   = 1'b0;
         cnt_d   = '0;
         done_d  = 1'b0;
         state_d = ((state_q == S_IDLE) || (state_q == S_DONE) || !pause) ? S_RUN : S_HOLD;
      end else begin
         unique case (state_q)
            S_RUN: begin
               if (pause) state_d = S_HOLD;
               else       cnt_d   = cnt_q + CNT_W'(1);
            end
            S_HOLD: begin
               if (!pause) state_d = S_RUN;
            end
            default: ;
         endcase
      end
   end

   // Rotate left by the offset. An offset of zero passes the data straight through.
   assign binary_out = (off_q == '0) ? data_q
                     : ((data_q << off_q) | (data_q >> (WIDTH_X - {1'b0, off_q})));
   assign window_out = binary_out[WIDTH-1 -: WIN_BITS];
   assign offset     = off_q;
   assign done       = done_q;

endmodule

// File: tb/tb_marquee_shifter.sv
module tb_marquee_shifter;

   localparam int DIV = 4;

   logic        clk;
   logic        reset;
   logic        pause;
   logic [1:0]  mode;
   logic [4:0]  step;
   logic        load_valid;
   logic        load_ready;
   logic [31:0] binary_in;
   logic [31:0] binary_out;
   logic [15:0] window_out;
   logic [4:0]  offset;
   logic        tick_out;
   logic        done;

   typedef struct {
      logic [4:0]  off;
      logic [31:0] bin;
      logic        dn;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   marquee_shifter #(.WIDTH(32), .WIN_BITS(16), .STEP_W(5), .DIV(DIV), .OFF_W(5)) dut (
      .sys_clk_in(clk), .reset(reset), .pause(pause), .mode(mode), .step(step),
      .load_valid(load_valid), .load_ready(load_ready), .binary_in(binary_in),
      .binary_out(binary_out), .window_out(window_out), .offset(offset),
      .tick_out(tick_out), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   function automatic logic [31:0] rotl_ref(input logic [31:0] d, input int n);
      logic [31:0] r;
      r = d;
      for (int i = 0; i < n; i++) r = {r[30:0], r[31]};
      return r;
   endfunction

   task automatic push(input logic [4:0] o, input logic [31:0] b, input logic dn);
      exp_t e;
      e.off = o; e.bin = b; e.dn = dn;
      exp_q.push_back(e);
   endtask

   // Monitor: every tick pops one expectation and checks the post-edge outputs.
   always begin
      @(negedge clk);
      if (tick_out && reset) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tick: got tick at offset %0d, expected no tick", offset);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("tick_offset", 32'(offset), 32'(e.off));
            check("tick_binary_out", binary_out, e.bin);
            check("tick_done", 32'(done), 32'(e.dn));
         end
      end
   end

   task automatic do_load(input logic [31:0] p, input logic [1:0] m, input logic [4:0] st);
      int n;
      @(negedge clk);
      mode = m; step = st; binary_in = p; load_valid = 1'b1;
      n = 0;
      while (!load_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         checks++; errors++;
         $display("FAIL load_timeout: got load_ready=0, expected 1");
      end
      @(posedge clk);
      #1;
      load_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d pending ticks, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_tick(input int budget);
      int n;
      n = 0;
      while (!tick_out && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!tick_out) begin
         checks++; errors++;
         $display("FAIL tick_timeout: got tick_out=0, expected 1");
      end
   endtask

   initial begin
      logic [4:0] pp_off [7];
      logic [4:0] os_off [4];
      logic [31:0] rl_bin [8];
      logic [31:0] rr_bin [4];
      int n;

      pp_off = '{5'd6, 5'd12, 5'd16, 5'd10, 5'd4, 5'd0, 5'd6};
      os_off = '{5'd5, 5'd10, 5'd15, 5'd16};
      rl_bin = '{32'h23456781, 32'h34567812, 32'h45678123, 32'h56781234,
                 32'h67812345, 32'h78123456, 32'h81234567, 32'h12345678};
      rr_bin = '{32'h78123456, 32'h56781234, 32'h34567812, 32'h12345678};

      reset = 1'b0; pause = 1'b0; mode = 2'b00; step = '0;
      load_valid = 1'b0; binary_in = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_binary_out", binary_out, 32'h0);
      check("rst_window_out", 32'(window_out), 32'h0);
      check("rst_offset", 32'(offset), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_tick_out", 32'(tick_out), 32'h0);
      check("rst_load_ready", 32'(load_ready), 32'h1);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_offset", 32'(offset), 32'h0);

      // Rotate left by 4: wraps back to the original after 8 ticks.
      for (int i = 0; i < 8; i++) push(5'((i + 1) * 4), rl_bin[i], 1'b0);
      do_load(32'h12345678, 2'b00, 5'd4);
      check("load_binary_out", binary_out, 32'h12345678);
      check("load_window_out", 32'(window_out), 32'h1234);
      wait_drain(8 * DIV + 10);

      // Rotate right by 8.
      for (int i = 0; i < 4; i++) push(5'(24 - i * 8), rr_bin[i], 1'b0);
      do_load(32'h12345678, 2'b01, 5'd8);
      wait_drain(4 * DIV + 10);

      // Ping-pong, step 6, range 0..16.
      for (int i = 0; i < 7; i++) push(pp_off[i], rotl_ref(32'h12345678, int'(pp_off[i])), 1'b0);
      do_load(32'h12345678, 2'b10, 5'd6);
      wait_drain(7 * DIV + 10);

      // One-shot, step 5: ends at 16 and then stops ticking.
      for (int i = 0; i < 4; i++)
         push(os_off[i], rotl_ref(32'h12345678, int'(os_off[i])), (i == 3));
      do_load(32'h12345678, 2'b11, 5'd5);
      wait_drain(4 * DIV + 10);
      repeat (3 * DIV) @(negedge clk);
      check("oneshot_done_level", 32'(done), 32'h1);
      check("oneshot_offset_hold", 32'(offset), 32'd16);
      check("oneshot_window", 32'(window_out), 32'h5678);
      check("oneshot_ready", 32'(load_ready), 32'h1);
      push(5'd5, 32'hFFE0001F, 1'b0);
      do_load(32'hFFFF0000, 2'b11, 5'd5);
      check("reload_done_clear", 32'(done), 32'h0);
      check("reload_offset", 32'(offset), 32'h0);
      check("reload_window", 32'(window_out), 32'hFFFF);
      wait_drain(DIV + 10);

      // load_valid held across a tick: refused on the tick, accepted next cycle.
      push(5'd1, 32'h00000002, 1'b0);
      do_load(32'h00000001, 2'b00, 5'd1);
      wait_tick(DIV + 5);
      binary_in = 32'hA5A50F0F; load_valid = 1'b1;
      check("tick_load_ready_low", 32'(load_ready), 32'h0);
      @(negedge clk);
      check("post_tick_load_ready", 32'(load_ready), 32'h1);
      check("post_tick_offset", 32'(offset), 32'h1);
      @(posedge clk);
      #1;
      check("held_load_offset", 32'(offset), 32'h0);
      check("held_load_binary", binary_out, 32'hA5A50F0F);
      wait_drain(4);

      // Pause with k=2 counts done: the tick lands DIV-k cycles after release.
      push(5'd1, 32'h4B4A1E1F, 1'b0);
      @(negedge clk);
      load_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      pause = 1'b1;
      repeat (6) @(negedge clk);
      check("pause_offset_hold", 32'(offset), 32'h0);
      check("pause_no_tick", 32'(tick_out), 32'h0);
      pause = 1'b0;
      n = 0;
      while (!tick_out && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("resume_tick_latency", 32'(n), 32'(DIV - 2));
      wait_drain(DIV + 5);

      // Asynchronous reset in the middle of a tick period.
      push(5'd4, 32'h23456781, 1'b0);
      do_load(32'h12345678, 2'b00, 5'd4);
      wait_drain(DIV + 10);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("async_rst_binary", binary_out, 32'h0);
      check("async_rst_window", 32'(window_out), 32'h0);
      check("async_rst_offset", 32'(offset), 32'h0);
      check("async_rst_ready", 32'(load_ready), 32'h1);
      check("async_rst_tick", 32'(tick_out), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2 * DIV + 2) @(negedge clk);
      check("post_rst_idle_binary", binary_out, 32'h0);
      check("post_rst_idle_offset", 32'(offset), 32'h0);
      check("pending_queue", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
